// File: rtl/score_pkg.sv
// score_pkg: shared default widths, score bias and the FIFO entry type for score_collector
package score_pkg;
    localparam int SCORE_WIDTH = 12;
    localparam int ID_WIDTH = 48;
    localparam int ZERO = 2 ** (SCORE_WIDTH - 1);
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic signed [SCORE_WIDTH:0] score;
    } score_entry_t;
endpackage

// File: rtl/score_fifo.sv
// score_fifo: synchronous show-ahead FIFO of score entries
// Ports: clk, rst (sync, active high); push/din write an entry unless full;
//        pop drops the head unless empty; dout is the head (zero when empty);
//        full, empty and level report occupancy.
module score_fifo import score_pkg::*; #(
    parameter type T = score_entry_t,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  T            din,
    input  logic        pop,
    output T            dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);
    T mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd;
    assign full = level == (AW+1)'(DEPTH);
    assign empty = level == '0;
    assign wr = push & ~full;
    assign rd = pop & ~empty;
    assign dout = empty ? T'('0) : mem[rp];
    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            wp <= wp + AW'(wr);
            rp <= rp + AW'(rd);
            level <= level + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/score_collector.sv
// score_collector: captures per-slot results on vld rising edges, arbitrates them
// round-robin into a show-ahead FIFO and outputs unbiased signed scores.
// Ports: clk, rst (sync, active high); results/IDs/vld per slot (slot 0 in the MSBs);
//        out_valid/out_ready/out_id/out_score head handshake; overflow sticky loss flag;
//        level FIFO occupancy.
// Optional macro SCORE_COLLECT_THRESH_EN adds threshold (results below it are discarded)
// and dropped (saturating count of discarded results).
module score_collector import score_pkg::*; #(
    parameter int SCORE_WIDTH = score_pkg::SCORE_WIDTH,
    parameter int ID_WIDTH = score_pkg::ID_WIDTH,
    parameter int SLOTS = 16,
    parameter int ZERO = 2 ** (SCORE_WIDTH - 1),
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SLOTS*SCORE_WIDTH-1:0]   results,
    input  logic [SLOTS*ID_WIDTH-1:0]      IDs,
    input  logic [SLOTS-1:0]               vld,
`ifdef SCORE_COLLECT_THRESH_EN
    input  logic [SCORE_WIDTH-1:0]         threshold,
    output logic [15:0]                    dropped,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ID_WIDTH-1:0]            out_id,
    output logic signed [SCORE_WIDTH:0]    out_score,
    output logic                           overflow,
    output logic [$clog2(FIFO_DEPTH):0]    level
);
    localparam int RW = $clog2(SLOTS);
    localparam logic [SCORE_WIDTH:0] ZW = (SCORE_WIDTH+1)'(ZERO);
    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic signed [SCORE_WIDTH:0] score;
    } entry_t;
    logic [SLOTS-1:0] vld_q, nw, cap, pending, gmask;
    logic [ID_WIDTH-1:0] hid [SLOTS];
    logic [SCORE_WIDTH-1:0] hsc [SLOTS];
    logic [RW-1:0] rr, gidx, s;
    logic gnt, full, empty;
    entry_t din, dout;
    // nw/cap are indexed by slot number; the ports carry slot 0 in the MSBs
    for (genvar j = 0; j < SLOTS; j++) begin : g_slot
        assign nw[j] = vld[SLOTS-1-j] & ~vld_q[SLOTS-1-j];
`ifdef SCORE_COLLECT_THRESH_EN
        assign cap[j] = nw[j] & (results[(SLOTS-1-j)*SCORE_WIDTH +: SCORE_WIDTH] >= threshold);
`else
        assign cap[j] = nw[j];
`endif
    end
    // scanning downwards leaves the lowest offset from rr as the winner
    always_comb begin
        gnt = 1'b0;
        gidx = '0;
        s = '0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            s = RW'((int'(rr) + k) % SLOTS);
            if (!full && pending[s]) begin
                gnt = 1'b1;
                gidx = s;
            end
        end
    end
    assign gmask = gnt ? SLOTS'(1) << gidx : '0;
    assign din = '{id: hid[gidx], score: $signed({1'b0, hsc[gidx]} - ZW)};
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '1;
            pending <= '0;
            rr <= '0;
            overflow <= 1'b0;
            for (int j = 0; j < SLOTS; j++) begin
                hid[j] <= '0;
                hsc[j] <= '0;
            end
        end else begin
            vld_q <= vld;
            // a slot being granted this cycle is free to take the new result
            overflow <= overflow | |(cap & pending & ~gmask);
            if (gnt) rr <= gidx == RW'(SLOTS - 1) ? '0 : gidx + 1'b1;
            for (int j = 0; j < SLOTS; j++) begin
                if (cap[j] && (!pending[j] || gmask[j])) begin
                    pending[j] <= 1'b1;
                    hid[j] <= IDs[(SLOTS-1-j)*ID_WIDTH +: ID_WIDTH];
                    hsc[j] <= results[(SLOTS-1-j)*SCORE_WIDTH +: SCORE_WIDTH];
                end else if (gmask[j]) begin
                    pending[j] <= 1'b0;
                end
            end
        end
    end
`ifdef SCORE_COLLECT_THRESH_EN
    logic [16:0] dsum;
    assign dsum = {1'b0, dropped} + 17'($countones(nw & ~cap));
    always_ff @(posedge clk)
        if (rst) dropped <= '0;
        else dropped <= dsum[16] ? 16'hffff : dsum[15:0];
`endif
    score_fifo #(.T(entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(gnt),
        .din(din),
        .pop(out_valid & out_ready),
        .dout(dout),
        .full(full),
        .empty(empty),
        .level(level)
    );
    assign out_valid = ~empty;
    assign out_id = dout.id;
    assign out_score = dout.score;
endmodule
